ddr_arbiter: RTL and testbench

//  Shares the single DDRAM port between two requesters (in0 = ROM download

---
 rtl/ddr_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ddr_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
// Two-port burst arbiter in front of the DDRAM port. Grants one requester a
// whole burst at a time; read bursts are held until every beat has returned,
// write bursts until every beat has been accepted. Ties go round-robin.
module ddr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,

    input  logic                    in0_rd,
    input  logic                    in0_wr,
    input  logic [ADDR_WIDTH-1:0]   in0_addr,
    input  logic [BURST_WIDTH-1:0]  in0_burst_len,
    input  logic [DATA_WIDTH-1:0]   in0_din,
    input  logic [DATA_WIDTH/8-1:0] in0_mask,
    output logic                    in0_wait_req,
    output logic                    in0_valid,
    output logic [DATA_WIDTH-1:0]   in0_dout,
    output logic                    in0_burst_done,

    input  logic                    in1_rd,
    input  logic                    in1_wr,
    input  logic [ADDR_WIDTH-1:0]   in1_addr,
    input  logic [BURST_WIDTH-1:0]  in1_burst_len,
    input  logic [DATA_WIDTH-1:0]   in1_din,
    input  logic [DATA_WIDTH/8-1:0] in1_mask,
    output logic                    in1_wait_req,
    output logic                    in1_valid,
    output logic [DATA_WIDTH-1:0]   in1_dout,
    output logic                    in1_burst_done,

    output logic                    ddr_rd,
    output logic                    ddr_wr,
    output logic [ADDR_WIDTH-1:0]   ddr_addr,
    output logic [BURST_WIDTH-1:0]  ddr_burst_len,
    output logic [DATA_WIDTH-1:0]   ddr_din,
    output logic [DATA_WIDTH/8-1:0] ddr_mask,
    input  logic                    ddr_wait_req,
    input  logic                    ddr_valid,
    input  logic [DATA_WIDTH-1:0]   ddr_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [BURST_WIDTH:0]   ONE     = 1;
    localparam logic [BURST_WIDTH-1:0] LEN_ONE = 1;

    logic [1:0]              state;
    logic                    owner;
    logic                    prio;
    logic [BURST_WIDTH:0]    beats_left;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [BURST_WIDTH-1:0]  lat_len;

    logic                    req0, req1, any_req, win, sel;
    logic                    sel_rd, sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [BURST_WIDTH-1:0]  sel_len;
    logic [DATA_WIDTH-1:0]   sel_din;
    logic [DATA_WIDTH/8-1:0] sel_mask;
    logic                    sel_wait, rd_acc, wr_acc, beat_vld, done;

    assign req0    = in0_rd | in0_wr;
    assign req1    = in1_rd | in1_wr;
    assign any_req = req0 | req1;
    // A lone requester wins; a tie goes to prio.
    assign win     = (req0 & req1) ? prio : req1;
    // Port whose command is on the bus: the winner while idle, else the owner.
    assign sel     = (state == IDLE) ? win : owner;

    assign sel_rd   = sel ? in1_rd        : in0_rd;
    assign sel_wr   = sel ? in1_wr        : in0_wr;
    assign sel_addr = sel ? in1_addr      : in0_addr;
    assign sel_len  = sel ? in1_burst_len : in0_burst_len;
    assign sel_din  = sel ? in1_din       : in0_din;
    assign sel_mask = sel ? in1_mask      : in0_mask;

    // Command forwarding, stall and per-beat strobes; all forced idle in reset.
    always_comb begin
        ddr_rd        = 1'b0;
        ddr_wr        = 1'b0;
        ddr_addr      = sel_addr;
        ddr_burst_len = sel_len;
        ddr_din       = sel_din;
        ddr_mask      = sel_mask;
        sel_wait      = 1'b1;
        rd_acc        = 1'b0;
        wr_acc        = 1'b0;
        beat_vld      = 1'b0;
        done          = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    ddr_rd   = any_req & sel_rd;
                    ddr_wr   = any_req & sel_wr & ~sel_rd;
                    sel_wait = ddr_wait_req;
                    rd_acc   = ddr_rd & ~ddr_wait_req;
                    wr_acc   = ddr_wr & ~ddr_wait_req;
                    done     = wr_acc & (sel_len <= LEN_ONE);
                end
                READ: begin
                    beat_vld = ddr_valid;
                    done     = ddr_valid & (beats_left == ONE);
                end
                WRITE: begin
                    ddr_wr        = sel_wr;
                    ddr_addr      = lat_addr;
                    ddr_burst_len = lat_len;
                    sel_wait      = ddr_wait_req;
                    wr_acc        = ddr_wr & ~ddr_wait_req;
                    done          = wr_acc & (beats_left == ONE);
                end
                default: ;
            endcase
        end
    end

    assign in0_wait_req   = sel ? 1'b1 : sel_wait;
    assign in1_wait_req   = sel ? sel_wait : 1'b1;
    assign in0_valid      = beat_vld & ~sel;
    assign in1_valid      = beat_vld &  sel;
    assign in0_burst_done = done & ~sel;
    assign in1_burst_done = done &  sel;
    assign in0_dout       = ddr_dout;
    assign in1_dout       = ddr_dout;

    // Grant state machine: burst beat counting and round-robin priority.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            prio       <= 1'b0;
            beats_left <= '0;
            lat_addr   <= '0;
            lat_len    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_acc) begin
                        owner      <= win;
                        beats_left <= (sel_len == '0) ? ONE : {1'b0, sel_len};
                        state      <= READ;
                    end else if (wr_acc) begin
                        if (sel_len <= LEN_ONE) begin
                            prio <= ~win;
                        end else begin
                            owner      <= win;
                            beats_left <= {1'b0, sel_len} - ONE;
                            lat_addr   <= sel_addr;
                            lat_len    <= sel_len;
                            state      <= WRITE;
                        end
                    end
                end
                READ: begin
                    if (ddr_valid) begin
                        beats_left <= beats_left - ONE;
                        if (beats_left == ONE) begin
                            prio  <= ~owner;
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_acc) begin
                        beats_left <= beats_left - ONE;
                        if (beats_left == ONE) begin
                            prio  <= ~owner;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: inputs driven on the falling edge,
// outputs checked 1ns later, state advances on the rising edge.
module tb_ddr_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        in0_rd, in0_wr, in1_rd, in1_wr;
    logic [31:0] in0_addr, in1_addr;
    logic [7:0]  in0_burst_len, in1_burst_len;
    logic [63:0] in0_din, in1_din;
    logic [7:0]  in0_mask, in1_mask;
    logic        in0_wait_req, in0_valid, in0_burst_done;
    logic        in1_wait_req, in1_valid, in1_burst_done;
    logic [63:0] in0_dout, in1_dout;
    logic        ddr_rd, ddr_wr;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_burst_len;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_mask;
    logic        ddr_wait_req, ddr_valid;
    logic [63:0] ddr_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    ddr_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .in0_rd(in0_rd), .in0_wr(in0_wr), .in0_addr(in0_addr),
        .in0_burst_len(in0_burst_len), .in0_din(in0_din), .in0_mask(in0_mask),
        .in0_wait_req(in0_wait_req), .in0_valid(in0_valid), .in0_dout(in0_dout),
        .in0_burst_done(in0_burst_done),
        .in1_rd(in1_rd), .in1_wr(in1_wr), .in1_addr(in1_addr),
        .in1_burst_len(in1_burst_len), .in1_din(in1_din), .in1_mask(in1_mask),
        .in1_wait_req(in1_wait_req), .in1_valid(in1_valid), .in1_dout(in1_dout),
        .in1_burst_done(in1_burst_done),
        .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
        .ddr_burst_len(ddr_burst_len), .ddr_din(ddr_din), .ddr_mask(ddr_mask),
        .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        in0_rd = 0; in0_wr = 0; in1_rd = 0; in1_wr = 0;
        ddr_valid = 0; ddr_wait_req = 0;
    endtask

    initial begin
        reset_n = 0;
        clear_reqs();
        in0_addr = 0; in1_addr = 0; in0_burst_len = 0; in1_burst_len = 0;
        in0_din = 0; in1_din = 0; in0_mask = 0; in1_mask = 0; ddr_dout = 0;

        // Reset forces outputs even with live requests and stray valids
        @(negedge clk_sys);
        in0_rd = 1; in1_wr = 1; ddr_valid = 1;
        #1;
        chk("rst_ddr_rd", ddr_rd, 0);
        chk("rst_ddr_wr", ddr_wr, 0);
        chk("rst_wait0", in0_wait_req, 1);
        chk("rst_wait1", in1_wait_req, 1);
        chk("rst_valid0", in0_valid, 0);
        chk("rst_done1", in1_burst_done, 0);
        @(negedge clk_sys);
        clear_reqs();
        reset_n = 1;

        // in0 read 0x100 len 4
        @(negedge clk_sys);
        in0_rd = 1; in0_addr = 32'h100; in0_burst_len = 4;
        #1;
        chk("a_ddr_rd", ddr_rd, 1);
        chk("a_addr", ddr_addr, 32'h100);
        chk("a_len", ddr_burst_len, 4);
        chk("a_wait0", in0_wait_req, 0);
        chk("a_wait1", in1_wait_req, 1);
        @(negedge clk_sys);
        in0_rd = 0;
        #1;
        chk("a_rd_busy", ddr_rd, 0);
        chk("a_wait0_busy", in0_wait_req, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1; ddr_dout = 64'hA000 + 64'(i);
            #1;
            chk("a_valid0", in0_valid, 1);
            chk("a_valid1", in1_valid, 0);
            chk("a_dout0", in0_dout, 64'hA000 + 64'(i));
            chk("a_done0", in0_burst_done, (i == 3) ? 1 : 0);
        end
        @(negedge clk_sys);
        ddr_valid = 0;

        // Fresh reset, then a tie: in0 first, in1 next, next tie back to in0
        reset_n = 0;
        @(negedge clk_sys);
        reset_n = 1;
        @(negedge clk_sys);
        in0_rd = 1; in0_addr = 32'h200; in0_burst_len = 2;
        in1_rd = 1; in1_addr = 32'h300; in1_burst_len = 1;
        #1;
        chk("b_tie_addr", ddr_addr, 32'h200);
        chk("b_tie_wait0", in0_wait_req, 0);
        chk("b_tie_wait1", in1_wait_req, 1);
        @(negedge clk_sys);
        in0_rd = 0;
        #1;
        chk("b_busy_wait1", in1_wait_req, 1);
        chk("b_busy_rd", ddr_rd, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1;
            #1;
            chk("b_valid0", in0_valid, 1);
            chk("b_wait1", in1_wait_req, 1);
            chk("b_done0", in0_burst_done, (i == 1) ? 1 : 0);
        end
        @(negedge clk_sys);
        ddr_valid = 0;
        #1;
        chk("b_grant1_addr", ddr_addr, 32'h300);
        chk("b_grant1_wait1", in1_wait_req, 0);
        chk("b_grant1_wait0", in0_wait_req, 1);
        @(negedge clk_sys);
        in1_rd = 0; ddr_valid = 1;
        #1;
        chk("b_valid1", in1_valid, 1);
        chk("b_valid0_off", in0_valid, 0);
        chk("b_done1", in1_burst_done, 1);
        @(negedge clk_sys);
        ddr_valid = 0; ddr_wait_req = 1;
        in0_rd = 1; in1_rd = 1;
        #1;
        chk("b_tie2_addr", ddr_addr, 32'h200);
        chk("b_tie2_wait0", in0_wait_req, 1);
        chk("b_tie2_wait1", in1_wait_req, 1);
        @(negedge clk_sys);
        clear_reqs();

        // in1 write len 3 with wait pattern 0,1,0,1,0; in0 blocked meanwhile
        @(negedge clk_sys);
        in1_wr = 1; in1_addr = 32'h400; in1_burst_len = 3;
        in1_din = 64'hD0; in1_mask = 8'hFF;
        #1;
        chk("c_wr", ddr_wr, 1);
        chk("c_addr", ddr_addr, 32'h400);
        chk("c_din0", ddr_din, 64'hD0);
        chk("c_wait1_0", in1_wait_req, 0);
        begin
            logic [63:0] dat [4];
            logic        wt   [4];
            dat = '{64'hD1, 64'hD1, 64'hD2, 64'hD2};
            wt  = '{1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk_sys);
                in0_rd = 1; in0_addr = 32'h500; in0_burst_len = 1;
                in1_addr = 32'hDEAD; in1_burst_len = 9;
                in1_din = dat[i]; ddr_wait_req = wt[i];
                #1;
                chk("c_wr_beat", ddr_wr, 1);
                chk("c_addr_hold", ddr_addr, 32'h400);
                chk("c_len_hold", ddr_burst_len, 3);
                chk("c_din", ddr_din, dat[i]);
                chk("c_wait1", in1_wait_req, wt[i]);
                chk("c_wait0", in0_wait_req, 1);
                chk("c_rd_blocked", ddr_rd, 0);
                chk("c_done1", in1_burst_done, (i == 3) ? 1 : 0);
            end
        end
        @(negedge clk_sys);
        in1_wr = 0; ddr_wait_req = 1;
        #1;
        chk("c_after_rd0", ddr_rd, 1);
        chk("c_after_addr", ddr_addr, 32'h500);
        @(negedge clk_sys);
        clear_reqs();

        // in0 write len 0: single beat, len 0 forwarded, done in accept cycle
        @(negedge clk_sys);
        in0_wr = 1; in0_addr = 32'h600; in0_burst_len = 0;
        in0_din = 64'h1234; in0_mask = 8'h0F;
        #1;
        chk("d_wr", ddr_wr, 1);
        chk("d_len0", ddr_burst_len, 0);
        chk("d_mask", ddr_mask, 8'h0F);
        chk("d_done0", in0_burst_done, 1);
        chk("d_wait0", in0_wait_req, 0);
        @(negedge clk_sys);
        in0_wr = 0; in1_rd = 1; in1_addr = 32'h700; ddr_wait_req = 1;
        #1;
        chk("d_idle_rd", ddr_rd, 1);
        chk("d_idle_addr", ddr_addr, 32'h700);
        chk("d_idle_wr", ddr_wr, 0);
        @(negedge clk_sys);
        clear_reqs();

        // Reset after beat 2 of an in0 len-4 read
        @(negedge clk_sys);
        in0_rd = 1; in0_addr = 32'h800; in0_burst_len = 4;
        #1;
        chk("e_rd", ddr_rd, 1);
        @(negedge clk_sys);
        in0_rd = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1;
            #1;
            chk("e_valid0", in0_valid, 1);
            chk("e_done0", in0_burst_done, 0);
        end
        @(negedge clk_sys);
        reset_n = 0; in0_rd = 1;
        #1;
        chk("e_rst_valid0", in0_valid, 0);
        chk("e_rst_wait0", in0_wait_req, 1);
        chk("e_rst_rd", ddr_rd, 0);
        @(negedge clk_sys);
        reset_n = 1; in0_rd = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1;
            #1;
            chk("e_late_valid0", in0_valid, 0);
            chk("e_late_valid1", in1_valid, 0);
            chk("e_late_done0", in0_burst_done, 0);
        end
        @(negedge clk_sys);
        ddr_valid = 0; in1_rd = 1; in1_addr = 32'h900; in1_burst_len = 2;
        #1;
        chk("e_in1_rd", ddr_rd, 1);
        chk("e_in1_addr", ddr_addr, 32'h900);
        chk("e_in1_wait", in1_wait_req, 0);
        @(negedge clk_sys);
        in1_rd = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1;
            #1;
            chk("e_in1_valid", in1_valid, 1);
            chk("e_in1_done", in1_burst_done, (i == 1) ? 1 : 0);
        end

        // Stray valids while idle; prio stays with in0
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys);
            ddr_valid = 1;
            #1;
            chk("f_stray_valid0", in0_valid, 0);
            chk("f_stray_valid1", in1_valid, 0);
            chk("f_stray_done1", in1_burst_done, 0);
        end
        @(negedge clk_sys);
        ddr_valid = 0; ddr_wait_req = 1;
        in0_rd = 1; in0_addr = 32'hA00; in1_rd = 1; in1_addr = 32'hB00;
        #1;
        chk("f_tie_addr", ddr_addr, 32'hA00);
        chk("f_tie_wait1", in1_wait_req, 1);
        @(negedge clk_sys);
        clear_reqs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
